freq_gate_ctrl: RTL
===================

# freq_gate_ctrl

Measurement sequencer for the frequency meter, wrapped around the 6-digit BCD event counter. It generates that counter's clear and enable (gate window) controls in the system clock domain. After each gate it samples the counter's 24-bit BCD result and presents it as a held reading with a one-cycle valid strobe for the display/readout stage.

## Interface
Parameters:
- GATE_CYCLES, 50000000: CLK cycles ENA stays high per measurement (1 s at 50 MHz); must be ≥ 1
- CLR_CYCLES, 4: CLK cycles CLR stays high before each gate; must be ≥ 1
- SETTLE_CYCLES, 2: CLK cycles between ENA falling and sampling; must be ≥ 1

Ports:
- CLK  input  1  system clock; all logic rising-edge
- RST  input  1  asynchronous, active-high reset
- RUN  input  1  level; high = measure continuously
- Q_IN  input  24  BCD count from the counter (6 digits, LSD in [3:0])
- ENA  output  1  gate enable to the counter
- CLR  output  1  clear to the counter
- DOUT  output  24  last captured BCD reading
- DVALID  output  1  one-cycle pulse when DOUT updates
- BUSY  output  1  high in any state except IDLE
- SAMPLE_ERR  output  1  sticky sample-mismatch flag (only with macro, else tied 0)

## Operation
- FSM states: IDLE, CLEAR, GATE, SETTLE, LATCH.
- IDLE:
  - ENA=0, CLR=1 (counter held cleared).
  - RUN=1 → CLEAR.
- CLEAR:
  - CLR=1, ENA=0 for exactly CLR_CYCLES cycles → GATE.
  - The counter clears synchronously to its own clock, so F_IN must toggle during CLEAR; the system integration guarantees this.
- GATE:
  - CLR=0, ENA=1 for exactly GATE_CYCLES cycles → SETTLE.
- SETTLE:
  - ENA=0, CLR=0 for SETTLE_CYCLES cycles → LATCH. This lets the counter's in-flight F_IN edge complete before Q_IN is sampled.
- LATCH:
  - DOUT ← Q_IN; DVALID=1 for that cycle.
  - Next state: CLEAR if RUN=1, else IDLE.
- RUN is sampled only in IDLE and at the end of LATCH. Deasserting RUN mid-measurement completes the current measurement, including its DVALID, then goes to IDLE.
- A single cycle counter of width $clog2(max(GATE_CYCLES, CLR_CYCLES, SETTLE_CYCLES)+1) reloads on each state entry.
- DOUT is never modified outside LATCH. The value passes through unchecked: no BCD validation, and wrap-around of the counter is not detected.

## Timing
- Reset values: state IDLE, ENA=0, CLR=1, DOUT=24'h000000, DVALID=0, BUSY=0, SAMPLE_ERR=0.
- Reset is asynchronous and valid in any state. Asserting it mid-GATE drops ENA immediately and discards the measurement; no DVALID is issued.
- All outputs are registered.
- RUN rising in IDLE at edge n: CLR still 1, BUSY=1 from edge n+1 (CLEAR).
- ENA high from the first GATE cycle for exactly GATE_CYCLES cycles.
- One measurement period is CLR_CYCLES + GATE_CYCLES + SETTLE_CYCLES + 1 cycles, LATCH counted as 1 (macro off).
- DVALID rises GATE_CYCLES + SETTLE_CYCLES cycles after ENA's first high cycle.
- Back-to-back measurements: CLEAR follows LATCH with no idle cycle.

## Configuration
- FREQ_GATE_DBL_SAMPLE_EN defined:
  - LATCH samples Q_IN on two consecutive cycles and accepts the reading only if both samples are equal; DVALID pulses in the accept cycle.
  - On mismatch, the sample pair is retried up to 3 pair attempts in total.
  - After a third mismatch, the last sample is captured, DVALID pulses, and SAMPLE_ERR is set. SAMPLE_ERR clears only on RST.
  - LATCH therefore lasts 2 to 6 cycles.
- Undefined: single-sample LATCH of 1 cycle; SAMPLE_ERR tied 0.

## Test plan
Run all scenarios with GATE_CYCLES=10, CLR_CYCLES=2, SETTLE_CYCLES=2.
- Reset, then hold RUN=0 for 20 cycles → ENA=0, CLR=1, BUSY=0, DVALID never asserts, DOUT=000000.
- RUN=1 with a counter model driven by F_IN at CLK/4 → CLR high 2 cycles, ENA high exactly 10 cycles, DVALID after 2 SETTLE cycles, DOUT=000002 or 000003 matching the model's final count.
- RUN held high with Q_IN forced to 24'h123456 during SETTLE/LATCH → repeated measurements every 15 cycles, each with DOUT=123456 and exactly one DVALID per period.
- RUN dropped on the third GATE cycle → measurement completes with one DVALID, then IDLE with CLR=1 and BUSY=0.
- RST pulsed on the fifth GATE cycle → ENA drops asynchronously, no DVALID, DOUT retains its previous value of 000000, state IDLE.
- With FREQ_GATE_DBL_SAMPLE_EN, Q_IN toggling between 000009 and 000010 every cycle in LATCH → 6-cycle LATCH, DVALID pulses once, SAMPLE_ERR=1 and stays set until RST.

Source files
------------

// File: rtl/freq_gate_ctrl.sv
// Measurement sequencer for the 6-digit BCD frequency counter: drives CLR/ENA and captures the result.
// Define FREQ_GATE_DBL_SAMPLE_EN for a double-sampled LATCH with retry and a sticky SAMPLE_ERR flag.
module freq_gate_ctrl #(
    parameter int GATE_CYCLES   = 50000000,
    parameter int CLR_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RUN,
    input  logic [23:0] Q_IN,
    output logic        ENA,
    output logic        CLR,
    output logic [23:0] DOUT,
    output logic        DVALID,
    output logic        BUSY,
    output logic        SAMPLE_ERR
);

    localparam int MAX_GC     = (GATE_CYCLES > CLR_CYCLES) ? GATE_CYCLES : CLR_CYCLES;
    localparam int MAX_CYCLES = (MAX_GC > SETTLE_CYCLES) ? MAX_GC : SETTLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // Counter counts down to zero, so each state loads its length minus one on entry.
    localparam logic [CNT_W-1:0] CLR_LOAD    = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE,
        LATCH
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             capture;

`ifdef FREQ_GATE_DBL_SAMPLE_EN
    logic [23:0] samp, samp_nxt;
    logic        phase, phase_nxt;   // high in the first cycle of a sample pair
    logic [1:0]  tries, tries_nxt;
    logic        err_q, err_nxt;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred on any path.
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
`ifdef FREQ_GATE_DBL_SAMPLE_EN
        samp_nxt  = samp;
        phase_nxt = phase;
        tries_nxt = tries;
        err_nxt   = err_q;
`endif
        unique case (state)
            IDLE: begin
                if (RUN) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = CLR_LOAD;
                end
            end
            CLEAR: begin
                if (cnt == '0) begin
                    state_nxt = GATE;
                    cnt_nxt   = GATE_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            GATE: begin
                if (cnt == '0) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = SETTLE_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = LATCH;
`ifdef FREQ_GATE_DBL_SAMPLE_EN
                    samp_nxt  = Q_IN;
                    phase_nxt = 1'b1;
                    tries_nxt = 2'd0;
`else
                    capture   = 1'b1;
`endif
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            LATCH: begin
`ifdef FREQ_GATE_DBL_SAMPLE_EN
                if (phase) begin
                    // Second sample of the pair; the third failing pair is accepted with an error.
                    phase_nxt = 1'b0;
                    if (Q_IN == samp || tries == 2'd2) begin
                        capture = 1'b1;
                        if (Q_IN != samp) begin
                            err_nxt = 1'b1;
                        end
                    end else begin
                        tries_nxt = tries + 2'd1;
                    end
                end else if (DVALID) begin
                    state_nxt = RUN ? CLEAR : IDLE;
                    cnt_nxt   = CLR_LOAD;
                end else begin
                    samp_nxt  = Q_IN;
                    phase_nxt = 1'b1;
                end
`else
                state_nxt = RUN ? CLEAR : IDLE;
                cnt_nxt   = CLR_LOAD;
`endif
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = CLR_LOAD;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up exactly with the state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            ENA    <= 1'b0;
            CLR    <= 1'b1;
            BUSY   <= 1'b0;
            DVALID <= 1'b0;
            DOUT   <= 24'h000000;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ENA    <= (state_nxt == GATE);
            CLR    <= (state_nxt == IDLE) || (state_nxt == CLEAR);
            BUSY   <= (state_nxt != IDLE);
            DVALID <= capture;
            if (capture) begin
                DOUT <= Q_IN;
            end
        end
    end

`ifdef FREQ_GATE_DBL_SAMPLE_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            samp  <= 24'h000000;
            phase <= 1'b0;
            tries <= 2'd0;
            err_q <= 1'b0;
        end else begin
            samp  <= samp_nxt;
            phase <= phase_nxt;
            tries <= tries_nxt;
            err_q <= err_nxt;
        end
    end

    assign SAMPLE_ERR = err_q;
`else
    assign SAMPLE_ERR = 1'b0;
`endif

endmodule
